// File: rtl/hazard_detect.sv
// Load-use / memory-wait / control hazard request generator with a stretched branch flush
// and a saturating stall-cycle counter.
module hazard_detect #(
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned BRANCH_PENALTY = 1,
    parameter int unsigned CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic              id_rs_read,
    input  logic              id_rt_read,
    input  logic              id_is_jump,
    input  logic [REG_AW-1:0] ex_wd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              mem_ex_hazard,
    output logic              j_ctrl_hazard,
    output logic              branch_ctrl_hazard,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int unsigned FLUSH_W = (BRANCH_PENALTY > 2) ? $clog2(BRANCH_PENALTY) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(BRANCH_PENALTY - 1);
    localparam bit HAS_FLUSH = (BRANCH_PENALTY > 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] BR_FLUSH = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

    logic mem_wait;
    logic load_use;
    logic idle_like;
    logic br_active;

    always_comb begin
        mem_wait = mem_req & ~mem_ready;
        load_use = ex_mem_read & (ex_wd != '0) &
                   ((id_rs_read & (id_rs_addr == ex_wd)) |
                    (id_rt_read & (id_rt_addr == ex_wd)));

        // The ready cycle of MEM_WAIT already behaves as IDLE, so a branch frozen in EX
        // flushes in the same cycle the memory access completes.
        idle_like = (state_q == IDLE) | ((state_q == MEM_WAIT) & ~mem_wait);
        br_active = (idle_like & ex_branch_taken & ~mem_wait) | (state_q == BR_FLUSH);

        branch_ctrl_hazard = rst_n & br_active & ~mem_wait;
        mem_ex_hazard      = rst_n & (mem_wait | (load_use & ~br_active));
        j_ctrl_hazard      = rst_n & id_is_jump & ~(mem_wait | (load_use & ~br_active)) &
                             ~br_active;
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE, MEM_WAIT: begin
                if (mem_wait) begin
                    state_d = MEM_WAIT;
                end else if (ex_branch_taken && HAS_FLUSH) begin
                    state_d     = BR_FLUSH;
                    flush_cnt_d = FLUSH_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            BR_FLUSH: begin
                if (mem_wait) begin
                    state_d     = MEM_WAIT;
                    flush_cnt_d = '0;
                end else if (flush_cnt_q <= FLUSH_W'(1)) begin
                    state_d     = IDLE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                flush_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (mem_ex_hazard && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            flush_cnt_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_detect.sv
// Directed + random bench for hazard_detect; two instances (penalty 3 / 4-bit counter and
// default parameters) share stimulus and are checked against a cycle-level behavioural model.
module tb_hazard_detect;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs_addr, id_rt_addr, ex_wd;
    logic       id_rs_read, id_rt_read, id_is_jump;
    logic       ex_mem_read, ex_branch_taken, mem_req, mem_ready;

    logic        a_meh, a_jch, a_bch;
    logic [3:0]  a_stall;
    logic        b_meh, b_jch, b_bch;
    logic [31:0] b_stall;

    int errors = 0;
    int checks = 0;

    // Model state: flush cycles still owed after the current one, and stall counts.
    int unsigned flush_left[2];
    logic [31:0] stall_m[2];
    logic        meh_m[2];

    always #5 clk = ~clk;

    hazard_detect #(.REG_AW(5), .BRANCH_PENALTY(3), .CNT_W(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_read(id_rs_read), .id_rt_read(id_rt_read), .id_is_jump(id_is_jump),
        .ex_wd(ex_wd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .mem_ex_hazard(a_meh), .j_ctrl_hazard(a_jch), .branch_ctrl_hazard(a_bch),
        .stall_cycles(a_stall)
    );

    hazard_detect u_b (
        .clk(clk), .rst_n(rst_n),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_read(id_rs_read), .id_rt_read(id_rt_read), .id_is_jump(id_is_jump),
        .ex_wd(ex_wd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .mem_ex_hazard(b_meh), .j_ctrl_hazard(b_jch), .branch_ctrl_hazard(b_bch),
        .stall_cycles(b_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned penalty(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic logic [31:0] cnt_max(input int k);
        return (k == 0) ? 32'd15 : 32'hFFFF_FFFF;
    endfunction

    // One pipeline cycle: check combinational outputs, clock, check counters.
    task automatic tick();
        logic mw, lu, bra;
        logic bch_e, meh_e, jch_e;
        #3;
        mw = mem_req & ~mem_ready;
        lu = ex_mem_read && (ex_wd != 5'd0) &&
             ((id_rs_read && id_rs_addr == ex_wd) || (id_rt_read && id_rt_addr == ex_wd));
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                bch_e = 1'b0; meh_e = 1'b0; jch_e = 1'b0;
                flush_left[k] = 0;
                stall_m[k]    = 32'd0;
            end else begin
                bra   = (flush_left[k] > 0) || (ex_branch_taken && !mw);
                bch_e = bra && !mw;
                meh_e = mw || (lu && !bra);
                jch_e = id_is_jump && !meh_e && !bra;
            end
            meh_m[k] = meh_e;
            if (k == 0) begin
                chk("a_branch_ctrl_hazard", {31'd0, a_bch}, {31'd0, bch_e});
                chk("a_mem_ex_hazard",      {31'd0, a_meh}, {31'd0, meh_e});
                chk("a_j_ctrl_hazard",      {31'd0, a_jch}, {31'd0, jch_e});
            end else begin
                chk("b_branch_ctrl_hazard", {31'd0, b_bch}, {31'd0, bch_e});
                chk("b_mem_ex_hazard",      {31'd0, b_meh}, {31'd0, meh_e});
                chk("b_j_ctrl_hazard",      {31'd0, b_jch}, {31'd0, jch_e});
            end
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (mw)                    flush_left[k] = 0;
                else if (flush_left[k] > 0) flush_left[k] = flush_left[k] - 1;
                else if (ex_branch_taken)  flush_left[k] = penalty(k) - 1;
                if (meh_m[k] && stall_m[k] != cnt_max(k)) stall_m[k] = stall_m[k] + 1;
            end
        end
        chk("a_stall_cycles", {28'd0, a_stall}, stall_m[0]);
        chk("b_stall_cycles", b_stall, stall_m[1]);
    endtask

    task automatic clr();
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; ex_wd = 5'd0;
        id_rs_read = 1'b0; id_rt_read = 1'b0; id_is_jump = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1; ex_wd = 5'd8; id_rs_read = 1'b1; id_rs_addr = 5'd8;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        flush_left[0] = 0; flush_left[1] = 0;
        stall_m[0] = 32'd0; stall_m[1] = 32'd0;
        @(posedge clk); #1;
        set_load_use(); mem_req = 1'b1; ex_branch_taken = 1'b1; id_is_jump = 1'b1;
        tick();
        clr();
        tick();
        rst_n = 1'b1;

        // Load-use on rs.
        set_load_use();
        tick();
        // Register $0 never hazards; unread rt match does not hazard.
        clr(); ex_mem_read = 1'b1; ex_wd = 5'd0; id_rs_read = 1'b1; id_rt_read = 1'b1;
        tick();
        clr(); ex_mem_read = 1'b1; ex_wd = 5'd9; id_rt_addr = 5'd9; id_rs_read = 1'b1;
        tick();
        id_rt_read = 1'b1;
        tick();
        // Plain jump.
        clr(); id_is_jump = 1'b1;
        tick();

        // Memory wait for three cycles, then ready.
        clr(); mem_req = 1'b1;
        repeat (3) tick();
        mem_ready = 1'b1;
        tick();

        // Taken-branch pulse, then load-use and jump during the flush.
        clr(); ex_branch_taken = 1'b1;
        tick();
        clr(); set_load_use(); id_is_jump = 1'b1;
        repeat (3) tick();

        // Branch held in EX during a two-cycle memory wait.
        clr(); ex_branch_taken = 1'b1; mem_req = 1'b1;
        repeat (2) tick();
        mem_ready = 1'b1;
        tick();
        clr();
        repeat (3) tick();

        // Memory wait arriving mid-flush discards the rest of the flush.
        ex_branch_taken = 1'b1;
        tick();
        clr(); mem_req = 1'b1;
        tick();
        mem_ready = 1'b1;
        tick();
        clr();
        tick();

        // Saturate the 4-bit counter, then reset in the middle of a flush.
        mem_req = 1'b1;
        repeat (20) tick();
        clr(); ex_branch_taken = 1'b1;
        tick();
        clr();
        tick();
        set_load_use(); id_is_jump = 1'b1; mem_req = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; mem_req = 1'b0;
        tick();
        clr();
        tick();

        // Randomized traffic with small register indices to force collisions.
        for (int i = 0; i < 400; i++) begin
            rst_n           = ($urandom_range(0, 63) != 0);
            id_rs_addr      = 5'($urandom_range(0, 3));
            id_rt_addr      = 5'($urandom_range(0, 3));
            ex_wd           = 5'($urandom_range(0, 3));
            id_rs_read      = 1'($urandom_range(0, 1));
            id_rt_read      = 1'($urandom_range(0, 1));
            id_is_jump      = ($urandom_range(0, 3) == 0);
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_req         = ($urandom_range(0, 2) == 0);
            mem_ready       = 1'($urandom_range(0, 1));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
